// File: rtl/mem_port_arbiter.sv
// Shares one cache/memory request port between instruction fetch and data access.
// One outstanding transaction; data has fixed priority with a fetch starvation guard.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int ERRTY_W      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic                i_req_valid,
  output logic                i_req_ready,
  input  logic [ADDR_W-1:0]   i_req_addr,
  input  logic                i_kill,
  output logic                i_resp_valid,
  output logic [DATA_W-1:0]   i_resp_rdata,
  output logic                i_resp_error,
  output logic [ERRTY_W-1:0]  i_resp_errty,

  input  logic                d_req_valid,
  output logic                d_req_ready,
  input  logic [ADDR_W-1:0]   d_req_addr,
  input  logic                d_req_wen,
  input  logic [DATA_W-1:0]   d_req_wdata,
  input  logic [DATA_W/8-1:0] d_req_wmask,
  output logic                d_resp_valid,
  output logic [DATA_W-1:0]   d_resp_rdata,
  output logic                d_resp_error,
  output logic [ERRTY_W-1:0]  d_resp_errty,

  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_wen,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_rdata,
  input  logic                mem_resp_error,
  input  logic [ERRTY_W-1:0]  mem_resp_errty
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_I = 2'd1,
    WAIT_D = 2'd2
  } state_t;

  state_t             state;
  logic               drop;
  logic [CNT_W-1:0]   starve_cnt;

  logic free;
  logic i_elig;
  logic d_elig;
  logic starved;
  logic grant_i;
  logic grant_d;
  logic i_fire;
  logic d_fire;

  // free is gated by rst_n so no request escapes while reset is held
  always_comb begin
    i_elig  = i_req_valid & ~i_kill;
    d_elig  = d_req_valid;
    starved = (starve_cnt >= CNT_W'(STARVE_LIMIT));
    free    = rst_n & ((state == IDLE) | mem_resp_valid);
    grant_i = free & i_elig & (~d_elig | starved);
    grant_d = free & d_elig & ~grant_i;
    i_fire  = i_req_valid & i_req_ready;
    d_fire  = d_req_valid & d_req_ready;
  end

  always_comb begin
    mem_req_valid = grant_i | grant_d;
    i_req_ready   = grant_i & mem_req_ready;
    d_req_ready   = grant_d & mem_req_ready;
    mem_req_addr  = '0;
    mem_req_wen   = 1'b0;
    mem_req_wdata = '0;
    mem_req_wmask = '0;
    if (grant_i) begin
      mem_req_addr = i_req_addr;
    end else if (grant_d) begin
      mem_req_addr  = d_req_addr;
      mem_req_wen   = d_req_wen;
      mem_req_wdata = d_req_wdata;
      mem_req_wmask = d_req_wmask;
    end
  end

  // Responses are forwarded combinationally in the cycle memory returns them
  always_comb begin
    d_resp_valid = mem_resp_valid & (state == WAIT_D);
    i_resp_valid = mem_resp_valid & (state == WAIT_I) & ~drop & ~i_kill;
    d_resp_rdata = '0;
    d_resp_error = 1'b0;
    d_resp_errty = '0;
    i_resp_rdata = '0;
    i_resp_error = 1'b0;
    i_resp_errty = '0;
    if (d_resp_valid) begin
      d_resp_rdata = mem_resp_rdata;
      d_resp_error = mem_resp_error;
      d_resp_errty = mem_resp_errty;
    end
    if (i_resp_valid) begin
      i_resp_rdata = mem_resp_rdata;
      i_resp_error = mem_resp_error;
      i_resp_errty = mem_resp_errty;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      drop       <= 1'b0;
      starve_cnt <= '0;
    end else begin
      if (i_fire) begin
        state <= WAIT_I;
      end else if (d_fire) begin
        state <= WAIT_D;
      end else if (mem_resp_valid) begin
        state <= IDLE;
      end

      // drop only persists while the killed fetch is still outstanding
      if ((state == WAIT_I) && !mem_resp_valid && i_kill) begin
        drop <= 1'b1;
      end else if ((state != WAIT_I) || mem_resp_valid) begin
        drop <= 1'b0;
      end

      if (i_fire || !i_elig) begin
        starve_cnt <= '0;
      end else if (!starved) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end

`ifdef DEBUG
  a_no_resp_in_idle: assert property (@(posedge clk) disable iff (!rst_n)
    !(mem_resp_valid && (state == IDLE)));
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a transaction-level model checks every
// cycle, and each scenario pins a few hand-computed values.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int EW = 2;
  localparam int SL = 4;

  logic          clk;
  logic          rst_n;
  logic          i_req_valid, i_req_ready, i_kill;
  logic [AW-1:0] i_req_addr;
  logic          i_resp_valid, i_resp_error;
  logic [DW-1:0] i_resp_rdata;
  logic [EW-1:0] i_resp_errty;
  logic          d_req_valid, d_req_ready, d_req_wen;
  logic [AW-1:0] d_req_addr;
  logic [DW-1:0] d_req_wdata;
  logic [DW/8-1:0] d_req_wmask;
  logic          d_resp_valid, d_resp_error;
  logic [DW-1:0] d_resp_rdata;
  logic [EW-1:0] d_resp_errty;
  logic          mem_req_valid, mem_req_ready, mem_req_wen;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_wdata;
  logic [DW/8-1:0] mem_req_wmask;
  logic          mem_resp_valid, mem_resp_error;
  logic [DW-1:0] mem_resp_rdata;
  logic [EW-1:0] mem_resp_errty;

  int vectors = 0;
  int miscompares = 0;
  int lat = 1;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .ERRTY_W(EW), .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_kill(i_kill), .i_resp_valid(i_resp_valid), .i_resp_rdata(i_resp_rdata),
    .i_resp_error(i_resp_error), .i_resp_errty(i_resp_errty),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_wen(d_req_wen), .d_req_wdata(d_req_wdata), .d_req_wmask(d_req_wmask),
    .d_resp_valid(d_resp_valid), .d_resp_rdata(d_resp_rdata),
    .d_resp_error(d_resp_error), .d_resp_errty(d_resp_errty),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .mem_resp_error(mem_resp_error), .mem_resp_errty(mem_resp_errty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents seen by the bench
  function automatic logic [31:0] img_data(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0000_0013;
    return a ^ 32'h5A5A_0000;
  endfunction
  function automatic logic img_err(input logic [31:0] a);
    return a[31:4] == 28'h0000_BAD;
  endfunction
  function automatic logic [1:0] img_ty(input logic [31:0] a);
    return img_err(a) ? (a[3:2] ^ 2'b10) : 2'b00;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder: fixed latency `lat`, answers from img_* for the captured address
  initial begin
    logic busy, fire, acc;
    int cnt;
    logic [31:0] a, raddr;
    busy = 0; cnt = 0; raddr = '0;
    mem_resp_valid = 0; mem_resp_rdata = '0; mem_resp_error = 0; mem_resp_errty = '0;
    forever begin
      @(negedge clk);
      fire = mem_resp_valid;
      acc  = mem_req_valid && mem_req_ready;
      a    = mem_req_addr;
      @(posedge clk);
      #1;
      if (fire) busy = 0;
      if (acc) begin
        busy = 1; cnt = 1; raddr = a;
      end else if (busy) begin
        cnt++;
      end
      mem_resp_valid = busy && (cnt == lat);
      mem_resp_rdata = mem_resp_valid ? img_data(raddr) : '0;
      mem_resp_error = mem_resp_valid ? img_err(raddr) : 1'b0;
      mem_resp_errty = mem_resp_valid ? img_ty(raddr) : 2'b00;
    end
  end

  // Transaction model: owner of the outstanding access (0 none, 1 fetch, 2 data)
  int          m_owner = 0;
  bit          m_drop = 0;
  int          m_starve = 0;
  logic [31:0] m_addr = '0;

  always @(negedge clk) begin
    bit ie, de, fr, pi, pd, e_iv, e_dv;
    if (!rst_n) begin
      chk("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
      chk("rst_i_req_ready", 64'(i_req_ready), 64'd0);
      chk("rst_d_req_ready", 64'(d_req_ready), 64'd0);
      chk("rst_i_resp_valid", 64'(i_resp_valid), 64'd0);
      chk("rst_d_resp_valid", 64'(d_resp_valid), 64'd0);
      m_owner = 0; m_drop = 0; m_starve = 0;
    end else begin
      ie = i_req_valid && !i_kill;
      de = d_req_valid;
      fr = (m_owner == 0) || mem_resp_valid;
      pi = fr && ie && (!de || m_starve >= SL);
      pd = fr && de && !pi;
      chk("mem_req_valid", 64'(mem_req_valid), 64'(pi || pd));
      chk("i_req_ready", 64'(i_req_ready), 64'(pi && mem_req_ready));
      chk("d_req_ready", 64'(d_req_ready), 64'(pd && mem_req_ready));
      if (pi) begin
        chk("req_addr_i", 64'(mem_req_addr), 64'(i_req_addr));
        chk("req_wen_i", 64'(mem_req_wen), 64'd0);
        chk("req_wdata_i", 64'(mem_req_wdata), 64'd0);
        chk("req_wmask_i", 64'(mem_req_wmask), 64'd0);
      end
      if (pd) begin
        chk("req_addr_d", 64'(mem_req_addr), 64'(d_req_addr));
        chk("req_wen_d", 64'(mem_req_wen), 64'(d_req_wen));
        chk("req_wdata_d", 64'(mem_req_wdata), 64'(d_req_wdata));
        chk("req_wmask_d", 64'(mem_req_wmask), 64'(d_req_wmask));
      end
      e_dv = mem_resp_valid && (m_owner == 2);
      e_iv = mem_resp_valid && (m_owner == 1) && !m_drop && !i_kill;
      chk("d_resp_valid", 64'(d_resp_valid), 64'(e_dv));
      chk("i_resp_valid", 64'(i_resp_valid), 64'(e_iv));
      if (e_dv) begin
        chk("d_resp_rdata", 64'(d_resp_rdata), 64'(img_data(m_addr)));
        chk("d_resp_error", 64'(d_resp_error), 64'(img_err(m_addr)));
        chk("d_resp_errty", 64'(d_resp_errty), 64'(img_ty(m_addr)));
      end
      if (e_iv) begin
        chk("i_resp_rdata", 64'(i_resp_rdata), 64'(img_data(m_addr)));
        chk("i_resp_error", 64'(i_resp_error), 64'(img_err(m_addr)));
        chk("i_resp_errty", 64'(i_resp_errty), 64'(img_ty(m_addr)));
      end
      if (pi && mem_req_ready) begin
        m_owner = 1; m_addr = i_req_addr; m_drop = 0;
      end else if (pd && mem_req_ready) begin
        m_owner = 2; m_addr = d_req_addr; m_drop = 0;
      end else if (mem_resp_valid && m_owner != 0) begin
        m_owner = 0; m_drop = 0;
      end else if (m_owner == 1 && i_kill) begin
        m_drop = 1;
      end
      if ((pi && mem_req_ready) || !ie) m_starve = 0;
      else if (m_starve < SL) m_starve++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance until an event is seen at a negedge; leaves the caller at that negedge
  task automatic run_until(input int sel, input int maxc, output int n);
    logic hit;
    n = 0;
    forever begin
      @(negedge clk);
      case (sel)
        0: hit = i_req_valid && i_req_ready;
        1: hit = d_req_valid && d_req_ready;
        2: hit = i_resp_valid;
        3: hit = d_resp_valid;
        default: hit = mem_resp_valid;
      endcase
      if (hit) return;
      if (n >= maxc) begin
        vectors++;
        miscompares++;
        $display("FAIL timeout sel=%0d after %0d cycles", sel, n);
        return;
      end
      step();
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 0; i_kill = 0; mem_req_ready = 1;
    i_req_valid = 1; i_req_addr = 32'h100;
    d_req_valid = 1; d_req_addr = 32'h8000; d_req_wen = 0; d_req_wdata = '0; d_req_wmask = '0;
    @(negedge clk);
    chk("reset_i_ready", 64'(i_req_ready), 64'd0);
    chk("reset_d_ready", 64'(d_req_ready), 64'd0);
    step();
    rst_n = 1; i_req_valid = 0; d_req_valid = 0;
    repeat (2) step();

    // Fetch only, latency 3, with two cycles of memory back-pressure first
    lat = 3; mem_req_ready = 0; i_req_valid = 1; i_req_addr = 32'h100;
    step(); step();
    mem_req_ready = 1;
    run_until(0, 10, n);
    chk("t1_accept_wait", 64'(n), 64'd0);
    step(); i_req_valid = 0;
    run_until(2, 10, n);
    chk("t1_latency", 64'(n), 64'd2);
    chk("t1_rdata", 64'(i_resp_rdata), 64'h13);
    step();

    // Both valid in IDLE: data store wins, fetch issues back-to-back
    lat = 2;
    i_req_valid = 1; i_req_addr = 32'h200;
    d_req_valid = 1; d_req_wen = 1; d_req_addr = 32'h8000;
    d_req_wdata = 32'hDEADBEEF; d_req_wmask = 4'b1111;
    run_until(1, 10, n);
    chk("t2_d_first", 64'(n), 64'd0);
    chk("t2_wen", 64'(mem_req_wen), 64'd1);
    chk("t2_i_held", 64'(i_req_ready), 64'd0);
    step(); d_req_valid = 0; d_req_wen = 0;
    run_until(3, 10, n);
    chk("t2_d_lat", 64'(n), 64'd1);
    chk("t2_b2b_ready", 64'(i_req_ready), 64'd1);
    chk("t2_b2b_addr", 64'(mem_req_addr), 64'h200);
    step(); i_req_valid = 0;
    run_until(2, 10, n);
    chk("t2_i_lat", 64'(n), 64'd1);
    chk("t2_i_rdata", 64'(i_resp_rdata), 64'h5A5A0200);
    step();

    // Starvation: data always valid, latency 1; fetch wins the 5th free slot, twice
    lat = 1;
    i_req_valid = 1; i_req_addr = 32'h500;
    d_req_valid = 1; d_req_addr = 32'h9000;
    run_until(0, 20, n);
    chk("t3_starve_first", 64'(n), 64'd4);
    step();
    run_until(0, 20, n);
    chk("t3_starve_again", 64'(n), 64'd4);
    step(); i_req_valid = 0; d_req_valid = 0;
    repeat (3) step();

    // Kill one cycle before the fetch response; next fetch is normal
    lat = 3; i_req_valid = 1; i_req_addr = 32'h300;
    run_until(0, 10, n);
    step(); i_req_valid = 0;
    step(); i_kill = 1;
    step(); i_kill = 0;
    run_until(4, 10, n);
    chk("t4_resp_time", 64'(n), 64'd0);
    chk("t4_dropped", 64'(i_resp_valid), 64'd0);
    step(); i_req_valid = 1; i_req_addr = 32'h400;
    run_until(0, 10, n);
    step(); i_req_valid = 0;
    run_until(2, 10, n);
    chk("t4_next_lat", 64'(n), 64'd2);
    chk("t4_next_rdata", 64'(i_resp_rdata), 64'h5A5A0400);
    step();

    // Kill coincident with the fetch response; waiting data is granted that cycle
    lat = 2; i_req_valid = 1; i_req_addr = 32'h600;
    run_until(0, 10, n);
    step(); i_req_valid = 0; d_req_valid = 1; d_req_addr = 32'h9004;
    step(); i_kill = 1;
    @(negedge clk);
    chk("t5_resp", 64'(mem_resp_valid), 64'd1);
    chk("t5_dropped", 64'(i_resp_valid), 64'd0);
    chk("t5_d_granted", 64'(d_req_ready), 64'd1);
    step(); i_kill = 0; d_req_valid = 0;
    run_until(3, 10, n);
    chk("t5_d_lat", 64'(n), 64'd1);
    chk("t5_d_rdata", 64'(d_resp_rdata), 64'h5A5A9004);
    step();

    // Reset during WAIT_D; the late response must be ignored
    lat = 3; d_req_valid = 1; d_req_wen = 1; d_req_addr = 32'h8004;
    d_req_wdata = 32'h12345678; d_req_wmask = 4'b0011;
    run_until(1, 10, n);
    step(); d_req_valid = 0; d_req_wen = 0; rst_n = 0; i_req_valid = 1; i_req_addr = 32'h700;
    @(negedge clk);
    chk("t6_rst_req", 64'(mem_req_valid), 64'd0);
    step(); rst_n = 1; i_req_valid = 0;
    step();
    @(negedge clk);
    chk("t6_late_resp", 64'(mem_resp_valid), 64'd1);
    chk("t6_no_d_resp", 64'(d_resp_valid), 64'd0);
    step(); i_req_valid = 1; i_req_addr = 32'h0;
    run_until(0, 10, n);
    chk("t6_idle_accept", 64'(n), 64'd0);
    step(); i_req_valid = 0;
    run_until(2, 10, n);
    chk("t6_rdata", 64'(i_resp_rdata), 64'h5A5A0000);
    step();

    // Fault responses on both ports
    lat = 1; d_req_valid = 1; d_req_addr = 32'hBAD0;
    run_until(1, 10, n);
    step(); d_req_valid = 0;
    run_until(3, 10, n);
    chk("t7_d_error", 64'(d_resp_error), 64'd1);
    chk("t7_d_errty", 64'(d_resp_errty), 64'd2);
    step(); i_req_valid = 1; i_req_addr = 32'hBAD4;
    run_until(0, 10, n);
    step(); i_req_valid = 0;
    run_until(2, 10, n);
    chk("t7_i_error", 64'(i_resp_error), 64'd1);
    chk("t7_i_errty", 64'(i_resp_errty), 64'd3);
    step();
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single cache/memory request port (CacheReq/CacheResp style) between the instruction-fetch requester and the data (load/store) requester.
- Allows one outstanding transaction at a time and routes each response back to the requester that owns it.
- Data port has fixed priority, with a starvation guard for fetch.
- Supports fetch kill (branch hazard): a killed in-flight fetch response is silently dropped.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, read/write data width.
- ERRTY_W, 2, width of the fault-type field (FaultTy).
- STARVE_LIMIT, 4, consecutive cycles fetch may be refused while data wins before fetch gets priority; must be ≥1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_req_valid  in  1  fetch request valid
- i_req_ready  out  1  fetch request accepted this cycle
- i_req_addr  in  ADDR_W  fetch address
- i_kill  in  1  fetch flush (branch hazard); drops any in-flight fetch response
- i_resp_valid  out  1  fetch response valid (one-cycle pulse)
- i_resp_rdata  out  DATA_W  fetch read data
- i_resp_error  out  1  fetch fault
- i_resp_errty  out  ERRTY_W  fetch fault type
- d_req_valid  in  1  data request valid
- d_req_ready  out  1  data request accepted this cycle
- d_req_addr  in  ADDR_W  data address
- d_req_wen  in  1  write enable
- d_req_wdata  in  DATA_W  write data
- d_req_wmask  in  DATA_W/8  byte mask
- d_resp_valid  out  1  data response valid (one-cycle pulse)
- d_resp_rdata  out  DATA_W  data read data
- d_resp_error  out  1  data fault
- d_resp_errty  out  ERRTY_W  data fault type
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_req_addr / mem_req_wen / mem_req_wdata / mem_req_wmask  out  ADDR_W / 1 / DATA_W / DATA_W/8  muxed request fields
- mem_resp_valid  in  1  memory response (one-cycle pulse)
- mem_resp_rdata / mem_resp_error / mem_resp_errty  in  DATA_W / 1 / ERRTY_W  memory response fields

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. All state is reset by rst_n low.
  - Reset state: IDLE, drop=0, starve_cnt=0.
  - While rst_n is low, all valid/ready outputs are 0. Data outputs are don't-care but driven 0.
- States:
  - IDLE: no outstanding transaction.
  - WAIT_I: fetch outstanding.
  - WAIT_D: data outstanding.
- free = (state==IDLE) | mem_resp_valid. A new request may issue in the same cycle the previous response returns (back-to-back, zero bubble).
- Eligibility:
  - i_elig = i_req_valid & !i_kill.
  - d_elig = d_req_valid.
- Grant selection (combinational, only when free):
  - Grant fetch if i_elig & (!d_elig | starve_cnt ≥ STARVE_LIMIT).
  - Else grant data if d_elig.
- Request path:
  - mem_req_valid = free & (grant_i | grant_d).
  - mem_req_* fields come from the granted port. A fetch forces wen=0, wmask=0, wdata=0.
  - x_req_ready = grant_x & free & mem_req_ready.
  - Handshake completes on x_req_valid & x_req_ready. The next state is then WAIT_I or WAIT_D; otherwise it is IDLE if mem_resp_valid, else it holds.
- Response path (same cycle as mem_resp_valid, no register):
  - In WAIT_D: d_resp_valid=1 and the response fields are forwarded.
  - In WAIT_I: i_resp_valid = !drop & !i_kill.
  - mem_resp_valid in IDLE is a protocol error and is ignored (assertion in DEBUG builds).
- Kill:
  - i_kill in WAIT_I (without mem_resp_valid) sets drop=1.
  - drop clears when the owned response arrives, and on any transition out of WAIT_I.
  - i_kill in IDLE or WAIT_D has no effect on state.
  - i_kill never cancels a data transaction.
- Starvation counter:
  - starve_cnt increments (saturating at STARVE_LIMIT) each cycle i_elig=1 and fetch is not accepted.
  - It clears on fetch acceptance or when i_elig=0.
- Memory back-pressure: if mem_req_ready=0 the grant is recomputed every cycle. The requester must hold valid and fields stable until ready.
- Reset mid-transaction: return to IDLE immediately. A late mem_resp_valid after reset is ignored.

Test Plan:
- Fetch only, addr 0x100, memory latency 3: i_req_ready pulses once; i_resp_valid 3 cycles later with rdata 0x00000013; d_resp_valid stays 0.
- Both valid in IDLE (i addr 0x200, d store addr 0x8000 wdata 0xDEADBEEF wmask 4'b1111): data granted first (mem_req_wen=1); fetch issues in the cycle d_resp_valid pulses (back-to-back).
- Data valid every cycle, latency 1, fetch held valid with STARVE_LIMIT=4: fetch is granted no later than the 5th free slot; starve_cnt returns to 0 after acceptance.
- Fetch in flight at 0x300, i_kill pulsed 1 cycle before response: i_resp_valid never asserts for it; next fetch to 0x400 responds normally.
- i_kill coincident with mem_resp_valid in WAIT_I: response dropped; a data request waiting the same cycle is granted.
- Assert rst_n=0 during WAIT_D, release, then mem_resp_valid arrives: no d_resp_valid; state IDLE; next fetch at 0x0 completes correctly.
